// File: rtl/seek_z_gen_pkg.sv
// rtl/seek_z_gen_pkg.sv - shared widths, z field bounds and state codes for seek_z_gen
package seek_z_gen_pkg;

  localparam int DATAWIDTH = 32;
  localparam int IN_W      = DATAWIDTH + 1;
  localparam int Z_W       = 2 * DATAWIDTH + 2;
  localparam int D_W       = DATAWIDTH + 2;

  localparam int Z_F0_HI = 65;
  localparam int Z_F0_LO = 59;
  localparam int Z_F1_HI = 58;
  localparam int Z_F1_LO = 46;
  localparam int Z_F2_HI = 45;
  localparam int Z_F2_LO = 33;
  localparam int Z_LO_HI = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_F0     = 3'd1;
  localparam logic [2:0] ST_F1     = 3'd2;
  localparam logic [2:0] ST_F2     = 3'd3;
  localparam logic [2:0] ST_LO     = 3'd4;
  localparam logic [2:0] ST_ISSUE  = 3'd5;
  localparam logic [2:0] ST_WAIT   = 3'd6;
  localparam logic [2:0] ST_RESULT = 3'd7;

  // Field-collecting states are the only ones that accept a beat.
  function automatic logic accepts_beat(input logic [2:0] st);
    return (st == ST_IDLE) || (st == ST_F0) || (st == ST_F1) ||
           (st == ST_F2) || (st == ST_LO);
  endfunction

endpackage

// File: rtl/seek_z_tmo.sv
// rtl/seek_z_tmo.sv - response watchdog: counts enabled cycles, flags the last allowed one
module seek_z_tmo #(
  parameter int TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the TIMEOUT-th enabled cycle since the last clear.
  assign expire = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/seek_z_gen.sv
// rtl/seek_z_gen.sv - packs four field beats into z, handshakes seek_cd, returns c/d
module seek_z_gen
  import seek_z_gen_pkg::*;
#(
  parameter int TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_W-1:0]      in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [Z_W-1:0]       z,
  output logic                 en,
  input  logic [DATAWIDTH-1:0] c_in,
  input  logic [D_W-1:0]       d_in,
  input  logic                 rdy_in,
  output logic [DATAWIDTH-1:0] res_c,
  output logic [D_W-1:0]       res_d,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 busy,
  output logic                 err
);

  logic [2:0]           state_q, state_d;
  logic [Z_W-1:0]       z_q, z_d;
  logic                 en_q, en_d;
  logic [DATAWIDTH-1:0] res_c_q, res_c_d;
  logic [D_W-1:0]       res_d_q, res_d_d;
  logic                 res_valid_q, res_valid_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic                 tmo_clr;
  logic                 tmo_en;
  logic                 tmo_expire;

  seek_z_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (reset),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  assign in_ready = accepts_beat(state_q);
  assign accept   = in_valid && in_ready;
  assign tmo_clr  = (state_q == ST_ISSUE);
  assign tmo_en   = (state_q == ST_WAIT);

  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    res_c_d     = res_c_q;
    res_d_d     = res_d_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;

    case (state_q)
      // F0 is an alias of IDLE: the first beat lands in field 0 either way.
      ST_IDLE, ST_F0: begin
        if (accept) begin
          z_d[Z_F0_HI:Z_F0_LO] = in_data[Z_F0_HI-Z_F0_LO:0];
          state_d              = ST_F1;
        end
      end
      ST_F1: begin
        if (accept) begin
          z_d[Z_F1_HI:Z_F1_LO] = in_data[Z_F1_HI-Z_F1_LO:0];
          state_d              = ST_F2;
        end
      end
      ST_F2: begin
        if (accept) begin
          z_d[Z_F2_HI:Z_F2_LO] = in_data[Z_F2_HI-Z_F2_LO:0];
          state_d              = ST_LO;
        end
      end
      ST_LO: begin
        if (accept) begin
          z_d[Z_LO_HI:0] = in_data[Z_LO_HI:0];
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A response on the expiry cycle still counts.
        if (rdy_in) begin
          res_c_d     = c_in;
          res_d_d     = d_in;
          res_valid_d = 1'b1;
          state_d     = ST_RESULT;
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rdy_in && (state_q != ST_WAIT)) begin
      err_d = 1'b1;
    end

    en_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      z_q         <= '0;
      en_q        <= 1'b0;
      res_c_q     <= '0;
      res_d_q     <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_q         <= z_d;
      en_q        <= en_d;
      res_c_q     <= res_c_d;
      res_d_q     <= res_d_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign z         = z_q;
  assign en        = en_q;
  assign res_c     = res_c_q;
  assign res_d     = res_d_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule
